// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: access size codes, FSM
// state encoding and the word width in bytes.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for sub-word accesses: byte enables, store
// data replicated onto every candidate lane, load data shifted down to
// bit 0, and detection of accesses that cannot be served (misaligned or
// reserved size).
module dmem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wlanes,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rword >> {i_lane, 3'b000};

  // Size decode: lanes written, data placement and alignment check.
  // The reserved size is folded into o_misalign so the top sees one fault.
  always_comb begin
    o_be       = 4'b0000;
    o_wlanes   = 32'h0;
    o_rdata    = 32'h0;
    o_misalign = 1'b0;
    case (mem_size_t'(i_size))
      SIZE_WORD: begin
        o_be       = 4'b1111;
        o_wlanes   = i_wdata;
        o_rdata    = i_rword;
        o_misalign = (i_lane != 2'b00);
      end
      SIZE_HALF: begin
        o_be       = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wlanes   = {2{i_wdata[15:0]}};
        o_rdata    = {16'h0, w_shifted[15:0]};
        o_misalign = i_lane[0];
      end
      SIZE_BYTE: begin
        o_be       = 4'b0001 << i_lane;
        o_wlanes   = {4{i_wdata[7:0]}};
        o_rdata    = {24'h0, w_shifted[7:0]};
        o_misalign = 1'b0;
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder behind the Memory-stage interface. Accepts one
// request at a time, waits a fixed number of cycles, then pulses
// MemReadyM with load data / error flag. Stalls the pipeline meanwhile.
//
//   state | meaning
//   IDLE  | waiting for MemReqM; busy follows MemReqM combinationally
//   WAIT  | counting down wait states on the latched request
//   RESP  | one-cycle response: MemReadyM=1, data and error valid
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemReadyM,
  output logic        MemBusyM,
  output logic        MemErrM
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int CW   = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  dmem_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_write;
  logic [1:0]    r_size;
  logic          r_ready;
  logic          r_err;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic            w_idle;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic            w_write;
  logic [1:0]      w_size;
  logic [IDXW-1:0] w_idx;
  logic            w_oor;
  logic [3:0]      w_be;
  logic [31:0]     w_wlanes;
  logic [31:0]     w_rdata;
  logic            w_misalign;
  logic            w_err;
  logic            w_enter_resp;
  logic            w_commit;

  // In IDLE the live inputs are used so a LATENCY=1 access can complete
  // straight from the accepting cycle; afterwards the latched copy wins.
  assign w_idle  = (r_state == IDLE);
  assign w_addr  = w_idle ? ALUOutM    : r_addr;
  assign w_wdata = w_idle ? WriteDataM : r_wdata;
  assign w_write = w_idle ? MemWriteM  : r_write;
  assign w_size  = w_idle ? MemSizeM   : r_size;
  assign w_idx   = w_addr[IDXW+1:2];
  assign w_oor   = |w_addr[31:IDXW+2];
  assign w_err   = w_misalign | w_oor;

  dmem_lane_align u_align (
    .i_size     (w_size),
    .i_lane     (w_addr[1:0]),
    .i_wdata    (w_wdata),
    .i_rword    (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wlanes   (w_wlanes),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign)
  );

  // The edge that moves the FSM into RESP is both the commit and the load-sample edge.
  always_comb begin
    w_enter_resp = 1'b0;
    if (LATENCY == 1) w_enter_resp = w_idle & MemReqM;
    else              w_enter_resp = (r_state == WAIT) && (r_cnt == CW'(1));
  end

  // A reset on the entering edge aborts the store as well as the response.
  assign w_commit = w_enter_resp & w_write & ~w_err & ~reset;

  // Stall is raised in the accepting cycle and dropped for the response.
  always_comb begin
    MemBusyM = 1'b0;
    case (r_state)
      IDLE:    MemBusyM = MemReqM;
      WAIT:    MemBusyM = 1'b1;
      default: MemBusyM = 1'b0;
    endcase
    if (reset) MemBusyM = 1'b0;
  end

  // Storage write with per-byte enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
      end
    end
  end

  // Request FSM, wait-state down-counter, request latch and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_size  <= 2'b00;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp & w_err;
      r_rdata <= (w_enter_resp & ~w_write & ~w_err) ? w_rdata : 32'h0;
      case (r_state)
        IDLE: begin
          if (MemReqM) begin
            r_addr  <= ALUOutM;
            r_wdata <= WriteDataM;
            r_write <= MemWriteM;
            r_size  <= MemSizeM;
            if (LATENCY == 1) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == CW'(1)) begin
            r_state <= RESP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MemReadyM = r_ready;
  assign MemErrM   = r_err;
  assign ReadDataM = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance A uses LATENCY=2, instance B uses
// LATENCY=1. Expected values come from a byte-addressed reference memory.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_a, we_a, rdy_a, bsy_a, err_a;
  logic [1:0]  sz_a;
  logic [31:0] ad_a, wd_a, rd_a;
  logic        req_b, we_b, rdy_b, bsy_b, err_b;
  logic [1:0]  sz_b;
  logic [31:0] ad_b, wd_b, rd_b;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .MemReqM(req_a), .MemWriteM(we_a), .MemSizeM(sz_a),
    .ALUOutM(ad_a), .WriteDataM(wd_a), .ReadDataM(rd_a), .MemReadyM(rdy_a),
    .MemBusyM(bsy_a), .MemErrM(err_a)
  );

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .MemReqM(req_b), .MemWriteM(we_b), .MemSizeM(sz_b),
    .ALUOutM(ad_b), .WriteDataM(wd_b), .ReadDataM(rd_b), .MemReadyM(rdy_b),
    .MemBusyM(bsy_b), .MemErrM(err_b)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [2][256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b00 && a[1:0] != 2'b00) ||
           (s == 2'b01 && a[0]) || (a >= 32'd256);
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 4 : (s == 2'b01) ? 2 : 1;
  endfunction

  function automatic logic [31:0] exp_load(input int d, input logic [1:0] s, input logic [31:0] a);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nbytes(s); i++) v[8*i +: 8] = mdl[d][int'(a[7:0]) + i];
    return v;
  endfunction

  task automatic model_store(input int d, input logic [1:0] s, input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < nbytes(s); i++) mdl[d][int'(a[7:0]) + i] = w[8*i +: 8];
  endtask

  task automatic drive(input int d, input logic q, input logic w, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] data);
    if (d == 0) begin
      req_a = q; we_a = w; sz_a = s; ad_a = a; wd_a = data;
    end else begin
      req_b = q; we_b = w; sz_b = s; ad_b = a; wd_b = data;
    end
  endtask

  // One request, called just after a rising edge; checks busy/ready every
  // cycle up to the expected response cycle, then the response itself.
  task automatic xact(input int d, input logic w, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] data, output logic [31:0] o_rd, output logic o_err);
    int          lat = (d == 0) ? 2 : 1;
    bit          e   = exp_err(s, a);
    logic [31:0] x   = (w || e) ? 32'h0 : exp_load(d, s, a);
    o_rd  = 32'h0;
    o_err = 1'b0;
    drive(d, 1'b1, w, s, a, data);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check("ready", 32'(d == 0 ? rdy_a : rdy_b), 32'(c == lat));
      check("busy",  32'(d == 0 ? bsy_a : bsy_b), 32'(c < lat));
      if (c == lat) begin
        o_rd  = (d == 0) ? rd_a : rd_b;
        o_err = (d == 0) ? err_a : err_b;
        check("rdata", o_rd, x);
        check("err", 32'(o_err), 32'(e));
      end
      @(posedge clk); #1;
    end
    drive(d, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    if (w && !e) model_store(d, s, a, data);
  endtask

  logic [31:0] rdv;
  logic        ev;
  logic [31:0] ab [3];
  logic [31:0] db [3];
  int          k;

  initial begin
    reset = 1'b1;
    drive(0, 1'b1, 1'b1, 2'b00, 32'h10, 32'h1234_5678);
    drive(1, 1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_busy",  32'(bsy_a), 32'd0);
      check("rst_ready", 32'(rdy_a), 32'd0);
      check("rst_err",   32'(err_a), 32'd0);
      check("rst_rdata", rd_a, 32'd0);
      check("rst_busy_b", 32'(bsy_b), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("idle_busy",  32'(bsy_a), 32'd0);
      check("idle_ready", 32'(rdy_a), 32'd0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 64; i++) xact(0, 1'b1, 2'b00, 32'(i * 4), $urandom, rdv, ev);

    xact(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, rdv, ev);
    xact(0, 1'b0, 2'b00, 32'h10, 32'h0, rdv, ev);
    check("word_rt", rdv, 32'hDEADBEEF);

    xact(0, 1'b1, 2'b00, 32'h10, 32'h0, rdv, ev);
    xact(0, 1'b1, 2'b10, 32'h11, 32'hFFFF_FFAA, rdv, ev);
    xact(0, 1'b0, 2'b00, 32'h10, 32'h0, rdv, ev);
    check("byte_store", rdv, 32'h0000AA00);
    xact(0, 1'b1, 2'b01, 32'h12, 32'hCDEF_1234, rdv, ev);
    xact(0, 1'b0, 2'b00, 32'h10, 32'h0, rdv, ev);
    check("half_store", rdv, 32'h1234AA00);
    xact(0, 1'b0, 2'b10, 32'h13, 32'h0, rdv, ev);
    check("byte_load", rdv, 32'h00000012);

    xact(0, 1'b1, 2'b00, 32'h22, 32'hFFFF_FFFF, rdv, ev);
    check("err_word_mis", 32'(ev), 32'd1);
    xact(0, 1'b0, 2'b00, 32'h20, 32'h0, rdv, ev);
    xact(0, 1'b0, 2'b01, 32'h21, 32'h0, rdv, ev);
    check("err_half_mis", 32'(ev), 32'd1);
    xact(0, 1'b0, 2'b11, 32'h20, 32'h0, rdv, ev);
    check("err_rsvd", 32'(ev), 32'd1);
    xact(0, 1'b1, 2'b00, 32'h100, 32'hA5A5_A5A5, rdv, ev);
    check("err_oor", 32'(ev), 32'd1);
    xact(0, 1'b0, 2'b00, 32'h0, 32'h0, rdv, ev);

    drive(0, 1'b1, 1'b1, 2'b00, 32'h04, 32'h55);
    @(negedge clk);
    check("abort_busy", 32'(bsy_a), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(rdy_a), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_noresp", 32'(rdy_a), 32'd0);
      @(posedge clk); #1;
    end
    xact(0, 1'b0, 2'b00, 32'h04, 32'h0, rdv, ev);

    repeat (60) begin
      logic [1:0]  s;
      logic [31:0] a;
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      xact(0, 1'($urandom_range(0, 1)), s, a, $urandom, rdv, ev);
    end

    for (int i = 0; i < 3; i++) begin
      ab[i] = 32'h40 + 32'(4 * i);
      db[i] = $urandom;
    end
    k = 0;
    drive(1, 1'b1, 1'b1, 2'b00, ab[0], db[0]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("b2b_ready", 32'(rdy_b), 32'(c % 2));
      check("b2b_busy",  32'(bsy_b), 32'(c % 2 == 0));
      @(posedge clk); #1;
      if (c % 2 == 1) begin
        model_store(1, 2'b00, ab[k], db[k]);
        k++;
        if (k < 3) drive(1, 1'b1, 1'b1, 2'b00, ab[k], db[k]);
        else       drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      xact(1, 1'b0, 2'b00, ab[i], 32'h0, rdv, ev);
      check("b2b_word", rdv, db[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
